// File: rtl/dbus_xbar.sv
// Data-bus crossbar between the MiniMIPS32 data port and NSLV handshaked slaves.
// Optional access timeout is built when DBUS_TIMEOUT_EN is defined.
module dbus_xbar #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BE_W    = DATA_W / 8,
  parameter int NSLV    = 4,
  parameter int SEL_W   = 2,
  parameter int SEL_LSB = 28,
  parameter int TIMEOUT = 15
) (
  input  logic                   cpu_clk_50M,
  input  logic                   cpu_rst,
  input  logic [ADDR_W-1:0]      daddr,
  input  logic                   dce,
  input  logic [BE_W-1:0]        we,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      dm,
  output logic                   stall,
  output logic                   bus_err,
  output logic [NSLV-1:0]        s_ce,
  output logic [ADDR_W-1:0]      s_addr,
  output logic [BE_W-1:0]        s_we,
  output logic [DATA_W-1:0]      s_din,
  input  logic [NSLV*DATA_W-1:0] s_rdata,
  input  logic [NSLV-1:0]        s_ready
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR
  } state_t;

  state_t state, state_nxt;

  logic [SEL_W-1:0]  req_idx;
  logic [SEL_W-1:0]  cur_idx;
  logic [NSLV-1:0]   req_onehot;
  logic              req_mapped;
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;
  logic              is_read;
  logic              timeout_hit;

  assign req_idx = daddr[SEL_LSB +: SEL_W];
  // The latched address carries the slave index for the whole access.
  assign cur_idx = s_addr[SEL_LSB +: SEL_W];
  assign is_read = (s_we == '0);
  assign stall   = (state != IDLE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    req_onehot = '0;
    sel_ready  = 1'b0;
    sel_rdata  = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (req_idx == SEL_W'(k)) begin
        req_onehot[k] = 1'b1;
      end
      if (cur_idx == SEL_W'(k)) begin
        sel_ready = s_ready[k] & s_ce[k];
        sel_rdata = s_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // An index at or beyond NSLV matches no slave, so the one-hot vector is empty.
  assign req_mapped = |req_onehot;

`ifdef DBUS_TIMEOUT_EN
  localparam logic [DATA_W-1:0] TMO_PATTERN = DATA_W'(32'hDEAD_BEEF);

  logic [7:0] tmo_cnt;

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      tmo_cnt <= '0;
    end else if (state != BUSY) begin
      tmo_cnt <= '0;
    end else if (!sel_ready) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  // Counter holds the number of completed idle BUSY cycles, so the abort lands
  // on the edge that ends the TIMEOUT-th BUSY cycle.
  assign timeout_hit = (state == BUSY) && (tmo_cnt == 8'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (dce) begin
          state_nxt = req_mapped ? BUSY : ERR;
        end
      end
      BUSY: begin
        if (sel_ready || timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      s_ce    <= '0;
      s_addr  <= '0;
      s_we    <= '0;
      s_din   <= '0;
      dm      <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dce) begin
            s_addr <= daddr;
            s_we   <= we;
            s_din  <= din;
            s_ce   <= req_onehot;
          end
        end
        BUSY: begin
          // Ready wins over a simultaneous timeout.
          if (sel_ready) begin
            s_ce <= '0;
            if (is_read) begin
              dm <= sel_rdata;
            end
          end
`ifdef DBUS_TIMEOUT_EN
          else if (timeout_hit) begin
            s_ce    <= '0;
            bus_err <= 1'b1;
            if (is_read) begin
              dm <= TMO_PATTERN;
            end
          end
`endif
        end
        ERR: begin
          bus_err <= 1'b1;
          if (is_read) begin
            dm <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_xbar.sv
// Scoreboard bench for dbus_xbar: random and directed accesses against a
// transaction-level model, with slave-side and master-side monitors.
module tb_dbus_xbar;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int BE_W    = 4;
  localparam int NSLV    = 3;
  localparam int SEL_W   = 2;
  localparam int SEL_LSB = 28;
  localparam int TIMEOUT = 15;
  localparam logic [DATA_W-1:0] TMO_PAT = 32'hDEAD_BEEF;

  logic                   clk = 1'b0;
  logic                   cpu_rst;
  logic [ADDR_W-1:0]      daddr;
  logic                   dce;
  logic [BE_W-1:0]        we;
  logic [DATA_W-1:0]      din;
  logic [DATA_W-1:0]      dm;
  logic                   stall;
  logic                   bus_err;
  logic [NSLV-1:0]        s_ce;
  logic [ADDR_W-1:0]      s_addr;
  logic [BE_W-1:0]        s_we;
  logic [DATA_W-1:0]      s_din;
  logic [NSLV*DATA_W-1:0] s_rdata;
  logic [NSLV-1:0]        s_ready;

  always #5 clk = ~clk;

  dbus_xbar #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .NSLV(NSLV),
    .SEL_W(SEL_W), .SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT)
  ) dut (
    .cpu_clk_50M(clk), .cpu_rst(cpu_rst),
    .daddr(daddr), .dce(dce), .we(we), .din(din),
    .dm(dm), .stall(stall), .bus_err(bus_err),
    .s_ce(s_ce), .s_addr(s_addr), .s_we(s_we), .s_din(s_din),
    .s_rdata(s_rdata), .s_ready(s_ready)
  );

  typedef struct {
    logic [NSLV-1:0]   ce;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   we;
    logic [DATA_W-1:0] din;
  } req_t;

  typedef struct {
    logic [DATA_W-1:0] dm;
    logic              err;
    int                cycles;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  bit force_ready = 1'b0;
  int cur_lat = 0;
  logic [DATA_W-1:0] cur_rdata = '0;
  logic [DATA_W-1:0] exp_dm = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave responder: selected slave answers after cur_lat extra BUSY cycles;
  // every unselected ready/rdata lane carries random noise.
  int busy_cnt = 0;
  always @(negedge clk) begin
    s_ready = NSLV'($urandom);
    for (int k = 0; k < NSLV; k++) s_rdata[k*DATA_W +: DATA_W] = $urandom;
    if (force_ready) s_ready = '1;
    if (s_ce != '0) begin
      for (int k = 0; k < NSLV; k++) begin
        if (s_ce[k]) begin
          s_ready[k] = (busy_cnt == cur_lat);
          if (busy_cnt == cur_lat) s_rdata[k*DATA_W +: DATA_W] = cur_rdata;
        end
      end
      busy_cnt++;
    end else begin
      busy_cnt = 0;
    end
  end

  // Master-side monitor: each stall fall is one completed access.
  bit   prev_stall = 1'b0;
  int   stall_len = 0;
  rsp_t got_rsp;
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall) stall_len++;
      if (prev_stall && !stall) begin
        if (rsp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_completion: got dm=%h bus_err=%b expected none", dm, bus_err);
        end else begin
          got_rsp = rsp_q.pop_front();
          check("dm", dm, got_rsp.dm);
          check("bus_err", bus_err, got_rsp.err);
          check("stall_len", stall_len, got_rsp.cycles);
        end
        stall_len = 0;
      end else begin
        check("bus_err_quiet", bus_err, 0);
      end
      prev_stall = stall;
    end else begin
      prev_stall = 1'b0;
      stall_len  = 0;
    end
  end

  // Slave-side monitor: request fields must match and stay constant while selected.
  logic [NSLV-1:0] prev_ce = '0;
  req_t cur_req;
  bit   have_req = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (s_ce != '0 && prev_ce == '0) begin
        if (req_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_select: got s_ce=%b s_addr=%h expected none", s_ce, s_addr);
          have_req = 1'b0;
        end else begin
          cur_req  = req_q.pop_front();
          have_req = 1'b1;
        end
      end
      if (s_ce != '0 && have_req) begin
        check("s_ce", s_ce, cur_req.ce);
        check("s_addr", s_addr, cur_req.addr);
        check("s_we", s_we, cur_req.we);
        check("s_din", s_din, cur_req.din);
      end
      if (s_ce == '0) have_req = 1'b0;
      prev_ce = s_ce;
    end else begin
      prev_ce  = '0;
      have_req = 1'b0;
    end
  end

  // Issue one access on the first IDLE cycle; optionally spam dce while stalled.
  task automatic issue(input logic [ADDR_W-1:0] a, input logic [BE_W-1:0] w,
                       input logic [DATA_W-1:0] d, input int lat,
                       input logic [DATA_W-1:0] rd, input bit spam);
    int   n;
    int   idx;
    bit   mapped;
    bit   tmo;
    req_t q;
    rsp_t r;
    n = 0;
    while (stall) begin
      if (spam) begin
        dce   = 1'b1;
        daddr = $urandom;
        we    = BE_W'($urandom);
        din   = $urandom;
      end else begin
        dce = 1'b0;
      end
      @(negedge clk);
      n++;
      if (n > 400) begin
        n_cmp++;
        n_err++;
        $display("FAIL stall_bound: got stall=%b after %0d cycles expected 0", stall, n);
        dce = 1'b0;
        return;
      end
    end
    daddr     = a;
    we        = w;
    din       = d;
    dce       = 1'b1;
    cur_lat   = lat;
    cur_rdata = rd;
    idx    = int'(a[SEL_LSB +: SEL_W]);
    mapped = (idx < NSLV);
    tmo    = 1'b0;
`ifdef DBUS_TIMEOUT_EN
    tmo = mapped && (lat >= TIMEOUT);
`endif
    if (mapped) begin
      q.ce   = NSLV'(1) << idx;
      q.addr = a;
      q.we   = w;
      q.din  = d;
      req_q.push_back(q);
    end
    if (w == '0) exp_dm = !mapped ? '0 : (tmo ? TMO_PAT : rd);
    r.dm     = exp_dm;
    r.err    = !mapped || tmo;
    r.cycles = !mapped ? 1 : (tmo ? TIMEOUT : lat + 1);
    rsp_q.push_back(r);
    @(negedge clk);
    dce = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (stall || rsp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 400) begin
        n_cmp++;
        n_err++;
        $display("FAIL drain_bound: got %0d pending expected 0", rsp_q.size());
        return;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    cpu_rst = 1'b1;
    dce     = 1'b0;
    daddr   = '0;
    we      = '0;
    din     = '0;
    repeat (3) @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_dm", dm, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_s_ce", s_ce, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_s_we", s_we, 0);
    check("rst_s_din", s_din, 0);
    cpu_rst = 1'b0;
    exp_dm  = '0;
    mon_en  = 1'b1;
    @(negedge clk);

    // Directed: fastest read, multi-cycle write, unmapped read, dce spam.
    issue(32'h1000_0040, 4'b0000, 32'h0, 0, 32'h1234_5678, 1'b0);
    issue(32'h0000_0100, 4'b0011, 32'hAABB_CCDD, 2, 32'h5555_5555, 1'b0);
    issue(32'h3000_0000, 4'b0000, 32'h0, 0, 32'h0, 1'b0);
    issue(32'h2000_0008, 4'b0000, 32'h0, 3, 32'h0BAD_F00D, 1'b0);
    issue(32'h0000_0004, 4'b0000, 32'h0, 0, 32'hCAFE_0001, 1'b1);
    issue(32'h3000_0010, 4'b1111, 32'h1111_2222, 0, 32'h0, 1'b0);
    issue(32'h3000_0020, 4'b0000, 32'h0, 0, 32'h0, 1'b0);
`ifdef DBUS_TIMEOUT_EN
    issue(32'h2000_0000, 4'b0000, 32'h0, 1000, 32'h7777_7777, 1'b0);
    issue(32'h2000_0000, 4'b0000, 32'h0, TIMEOUT - 1, 32'h7777_7777, 1'b0);
    issue(32'h1000_0000, 4'b0001, 32'h99, TIMEOUT + 3, 32'h0, 1'b0);
`endif

    for (int i = 0; i < 200; i++) begin
      logic [ADDR_W-1:0] a;
      logic [BE_W-1:0]   w;
      int                lat;
      a = $urandom;
      a[SEL_LSB +: SEL_W] = SEL_W'($urandom_range(0, 3));
      w = ($urandom_range(0, 1) == 0) ? '0 : BE_W'($urandom);
`ifdef DBUS_TIMEOUT_EN
      lat = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 2)
                                        : $urandom_range(0, 4);
`else
      lat = $urandom_range(0, 4);
`endif
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      issue(a, w, $urandom, lat, $urandom, $urandom_range(0, 2) == 0);
    end
    drain();

    // Reset in the middle of a slave-2 read; a late ready must be ignored.
    mon_en  = 1'b0;
    daddr   = 32'h2000_0010;
    we      = '0;
    din     = '0;
    cur_lat = 50;
    dce     = 1'b1;
    @(negedge clk);
    dce = 1'b0;
    check("mid_busy_stall", stall, 1);
    check("mid_busy_s_ce", s_ce, 3'b100);
    @(negedge clk);
    cpu_rst = 1'b1;
    @(negedge clk);
    cpu_rst = 1'b0;
    check("abort_s_ce", s_ce, 0);
    check("abort_stall", stall, 0);
    check("abort_dm", dm, 0);
    check("abort_bus_err", bus_err, 0);
    check("abort_s_addr", s_addr, 0);
    force_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("late_ready_stall", stall, 0);
      check("late_ready_dm", dm, 0);
      check("late_ready_s_ce", s_ce, 0);
    end
    force_ready = 1'b0;

    check("req_q_empty", req_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dbus_xbar.md
# dbus_xbar

Parametrised data-bus crossbar between the MiniMIPS32 core's data port (`daddr`/`dce`/`we`/`din`/`dm`) and up to NSLV data slaves (data RAM, MMIO blocks). It replaces the single fixed-latency data RAM hookup in the system top.

- It decodes a slave index from the address and presents a held request to the selected slave.
- It waits for a per-slave ready handshake and returns read data with a stall signal to the core.
- It flags unmapped and, optionally, timed-out accesses.

## Interface

Parameters:

- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; must be a multiple of 8; `BE_W = DATA_W/8`.
- `NSLV`, 4, number of slave channels, 1..2^`SEL_W`.
- `SEL_W`, 2, width of the slave-select field.
- `SEL_LSB`, 28, LSB of the select field; `idx = daddr[SEL_LSB +: SEL_W]`.
- `TIMEOUT`, 15, busy cycles before abort (only with `DBUS_TIMEOUT_EN`), 1..255.

Ports:

- `cpu_clk_50M`, in, 1, sole clock; all state updates on its rising edge.
- `cpu_rst`, in, 1, synchronous, active-high reset.
- `daddr`, in, `ADDR_W`, master address.
- `dce`, in, 1, master request strobe.
- `we`, in, `BE_W`, byte write enables; all-zero means read.
- `din`, in, `DATA_W`, write data.
- `dm`, out, `DATA_W`, registered read data.
- `stall`, out, 1, bridge busy; master must hold off new requests.
- `bus_err`, out, 1, one-cycle error pulse.
- `s_ce`, out, `NSLV`, one-hot slave select, registered.
- `s_addr`, out, `ADDR_W`, latched address, shared by all slaves.
- `s_we`, out, `BE_W`, latched byte enables, shared.
- `s_din`, out, `DATA_W`, latched write data, shared.
- `s_rdata`, in, `NSLV*DATA_W`, slave k read data at `[k*DATA_W +: DATA_W]`.
- `s_ready`, in, `NSLV`, slave k completes when `s_ce[k]` and `s_ready[k]` are both 1 at a clock edge.

## Operation

- FSM states: IDLE, BUSY, ERR. `stall = (state != IDLE)`, decoded from the state register.
- IDLE:
  - `dce=1` accepts the request and latches `daddr`/`we`/`din` into `s_addr`/`s_we`/`s_din`.
  - If `idx < NSLV`: `s_ce[idx]` goes high and the FSM moves to BUSY.
  - Otherwise: `s_ce` stays 0 and the FSM moves to ERR.
  - `dce=0` leaves the state unchanged.
- BUSY:
  - `s_ce` and the latched fields are held constant.
  - On an edge where `s_ready[idx]=1`: `s_ce` clears and the FSM returns to IDLE.
  - If the latched `we == 0`, `dm` loads `s_rdata[idx]`; writes leave `dm` unchanged.
  - `s_ready` bits of unselected slaves are ignored.
- ERR (unmapped index): lasts one cycle, then IDLE. On that edge `bus_err` pulses high for 1 cycle and, for reads, `dm` loads 0.
- `dce` asserted while `stall=1` is ignored; no request is queued.
- `cpu_rst` (any state, including mid-BUSY) forces the following on the next edge:
  - state IDLE;
  - `s_ce`, `s_addr`, `s_we`, `s_din` = 0;
  - `dm` = 0, `bus_err` = 0, timeout counter = 0.
  - A slave in the middle of a transaction is abandoned.
- Reset values: all outputs 0; `stall` = 0.

## Timing

- Request accepted at edge T (IDLE, `dce=1`). From T+1: `s_ce` high and `stall=1`.
- Earliest slave completion is `s_ready=1` sampled at edge T+1. Then `dm` is valid and `stall=0` in the cycle after T+1, and a new request may be accepted at edge T+2.
- General case: completion at edge T+k gives `stall` high for k cycles, and `dm` is valid from T+k until the next read completes.
- Unmapped access: `stall` high 1 cycle; `bus_err` is high in the same cycle that `dm=0` becomes visible.
- Back-to-back requests: one request per k+1 cycles minimum.
- `s_ready` is sampled only in BUSY. A ready asserted in the same cycle as the IDLE→BUSY edge is not seen.

## Configuration

- `DBUS_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without completion.
  - When it reaches `TIMEOUT` with no ready, the access aborts on that edge:
    - `s_ce` clears and the FSM returns to IDLE;
    - `bus_err` pulses for 1 cycle;
    - reads load `dm = 32'hDEAD_BEEF` (low `DATA_W` bits of the pattern, zero-extended if `DATA_W > 32`).
  - Ready and timeout on the same edge: ready wins, normal completion.
- Undefined: no counter is built and BUSY waits indefinitely. `bus_err` is driven only by unmapped accesses.

## Test plan

- Read, slave 1 (`daddr=0x1000_0040`, `we=0`), `s_ready[1]` at T+1, `s_rdata` slice 1 = `0x1234_5678` -> `s_ce=4'b0010` for 1 cycle, `stall` high 1 cycle, `dm=0x1234_5678` at T+2, `bus_err=0`.
- Write, slave 0, `we=4'b0011`, `din=0xAABB_CCDD`, ready after 3 BUSY cycles -> `s_we=0011` and `s_din=0xAABB_CCDD` held for 3 cycles, `stall` high 3 cycles, `dm` unchanged.
- `NSLV=3`, read `daddr=0x3000_0000` -> no `s_ce` activity, `stall` high 1 cycle, `bus_err` 1-cycle pulse, `dm=0`.
- `DBUS_TIMEOUT_EN`, `TIMEOUT=15`, read slave 2 and never assert ready -> abort after 15 BUSY cycles, `dm=0xDEAD_BEEF`, `bus_err` pulse. Repeat with ready on cycle 15 -> normal data, no error.
- `cpu_rst` asserted on the 2nd BUSY cycle of a slave-3 read -> next edge: `s_ce=0`, `stall=0`, `dm=0`. A late `s_ready[3]` afterwards is ignored.
- `dce` asserted every cycle during a 4-cycle BUSY -> only the first request reaches a slave, and the next request is accepted on the first IDLE cycle.
